mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Iterative unsigned multiply/divide controller that time-shares the core's 32-bit ALU to execute MULTU and DIVU, producing a 64-bit HI/LO result. It sits beside the ALU in the execute stage. While busy it owns the ALU's control and operand inputs, and it stalls the pipeline through `busy`. It uses only existing ALU functions (add `ALUCtl=2`, subtract `ALUCtl=6`); carry and compare decisions stay inside the sequencer.

## Interface
- No parameters; datapath width fixed at 32.
- `clk  in  1`  rising-edge clock.
- `rst_n  in  1`  asynchronous, active-low reset.
- `start  in  1`  request; sampled only when `busy=0`.
- `op  in  1`  0 = MULTU, 1 = DIVU.
- `rs_val  in  32`  multiplicand / dividend.
- `rt_val  in  32`  multiplier / divisor.
- `busy  out  1`  operation in progress; the ALU is owned by the sequencer.
- `done  out  1`  one-cycle pulse; `hi`/`lo`/`err` valid.
- `hi  out  32`  product[63:32] / remainder.
- `lo  out  32`  product[31:0] / quotient.
- `err  out  1`  divide-by-zero or unsupported op; valid with `done`.
- `alu_ctl  out  4`  ALU control.
- `alu_a  out  32`  ALU operand A.
- `alu_b  out  32`  ALU operand B.
- `alu_out  in  32`  ALU result, combinational in the same cycle.

## Operation
- FSM states: IDLE, MUL, DIV, DONE; 5-bit iteration counter `cnt`.
- IDLE or DONE with `start=1` latches `rs_val`/`rt_val` and clears `err`.
  - `op=0`: `hi=0`, `lo=rt_val`, multiplicand register=`rs_val`, go to MUL.
  - `op=1`, `rt_val!=0`: `hi=0`, `lo=rs_val`, divisor register=`rt_val`, go to DIV.
  - `op=1`, `rt_val==0`: `hi=rs_val`, `lo=32'hFFFF_FFFF`, `err=1`, go to DONE.
  - In all cases `cnt=0`.
- MUL step (one per cycle):
  - Drive `alu_ctl=2`, `alu_a=hi`, `alu_b = lo[0] ? mcand : 0`.
  - Compute `carry = (alu_out < hi)` as an unsigned compare.
  - Update `{hi,lo} <= {carry, alu_out, lo[31:1]}` (33+32 bits, take the upper 64 after the right shift).
- DIV step (restoring, one per cycle):
  - Form `r = {hi[30:0], lo[31]}` and `t = hi[31]`.
  - Drive `alu_ctl=6`, `alu_a=r`, `alu_b=divisor`.
  - If `t | (r >= divisor)`: `hi <= alu_out`, `lo <= {lo[30:0],1}`.
  - Otherwise: `hi <= r`, `lo <= {lo[30:0],0}`.
- After the step with `cnt==31`, go to DONE; otherwise increment `cnt`.
- DONE: `done=1` for one cycle, then IDLE unless a new `start` is accepted.
- ALU drive in IDLE/DONE: `alu_ctl=0`, `alu_a=0`, `alu_b=0`.
- `hi`/`lo`/`err` hold their values until the next accepted `start`.
- All arithmetic is unsigned, modulo 2^32 per ALU step; there is no overflow flag.

## Timing
- Reset (async, any state):
  - State→IDLE, `cnt=0`.
  - `busy=0`, `done=0`, `err=0`, `hi=0`, `lo=0`.
  - ALU outputs 0.
  - An in-flight operation is aborted with no `done`.
- `busy` and `done` are registered (decoded from the state register).
- `busy=1` exactly in MUL/DIV.
- For a `start` accepted at edge E0:
  - `busy` is high for cycles 1..32.
  - `done` is high in cycle 33.
  - Latency is 33 cycles.
- Divide-by-zero: `done` in cycle 1, `busy` never asserted.
- `start` while `busy=1` is ignored; no queuing.
- `start` in the DONE cycle is accepted: back-to-back, `busy` rises in the next cycle.
- `op`/`rs_val`/`rt_val` are sampled only at acceptance; changes during `busy` have no effect.
- ALU outputs are combinational from state/registers; `alu_out` must settle within the same cycle.

## Configuration
- `MDU_DIV_EN` defined: DIV state, divisor register and divide datapath are compiled in; behaviour as above.
- `MDU_DIV_EN` undefined: `op=1` with `start` goes directly to DONE with `hi=0`, `lo=0`, `err=1`. MULTU is unchanged, and no DIV state logic is present.

## Test plan
- Multiply, small operands:
  - Reset, then `start`, `op=0`, `rs=6`, `rt=7`.
  - Expect `done` in cycle 33 with `hi=0`, `lo=42`, `err=0`, and `busy` high for exactly 32 cycles.
- Multiply, carry path: `op=0`, `rs=rt=32'hFFFF_FFFF` → `hi=32'hFFFF_FFFE`, `lo=32'h0000_0001`.
- Divide (`MDU_DIV_EN`):
  - `op=1`, `rs=100`, `rt=7` → `lo=14`, `hi=2`.
  - `op=1`, `rs=32'hFFFF_FFFF`, `rt=1` → `lo=32'hFFFF_FFFF`, `hi=0`.
- Divide-by-zero: `op=1`, `rs=5`, `rt=0` → `done` in cycle 1, `hi=5`, `lo=32'hFFFF_FFFF`, `err=1`, `busy` stays 0.
- Busy and back-to-back:
  - Pulse `start` (`rs=3`, `rt=3`) at cycle 10 of a running `6*7`; it is ignored, result 42.
  - Then `start` (`rs=3`, `rt=5`) in the DONE cycle; it is accepted, giving `lo=15` 33 cycles later.
- Reset mid-operation:
  - Assert `rst_n=0` at cycle 15 of a multiply.
  - Expect `busy`, `done`, `hi`, `lo` all 0 immediately, and no `done` after release.
  - A new `6*7` then completes normally.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULTU/DIVU controller that borrows the execute-stage ALU for 32 steps.
// Define MDU_DIV_EN to compile in the restoring divider; without it DIVU completes at once with err.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out
);
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic        err_q, err_d;
    logic        carry;
`ifdef MDU_DIV_EN
    logic [31:0] divisor_q, divisor_d, div_r;
    logic        div_take;
`endif

`ifdef MDU_DIV_EN
    assign busy = (state_q == MUL) || (state_q == DIV);
`else
    assign busy = state_q == MUL;
`endif
    assign done = state_q == DONE;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign err  = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        err_d     = err_q;
        alu_ctl   = 4'd0;
        alu_a     = '0;
        alu_b     = '0;
        carry     = 1'b0;
`ifdef MDU_DIV_EN
        divisor_d = divisor_q;
        div_r     = {hi_q[30:0], lo_q[31]};
        div_take  = 1'b0;
`endif
        case (state_q)
            MUL: begin
                alu_ctl = 4'd2;
                alu_a   = hi_q;
                alu_b   = lo_q[0] ? mcand_q : '0;
                // the ALU has no carry out, so recover it from wraparound
                carry   = alu_out < hi_q;
                {hi_d, lo_d} = {carry, alu_out, lo_q[31:1]};
                state_d = (cnt_q == 5'd31) ? DONE : MUL;
                cnt_d   = cnt_q + 5'd1;
            end
`ifdef MDU_DIV_EN
            DIV: begin
                alu_ctl  = 4'd6;
                alu_a    = div_r;
                alu_b    = divisor_q;
                // hi[31] set means the shifted remainder is >= 2^32, so it always covers the divisor
                div_take = hi_q[31] | (div_r >= divisor_q);
                hi_d     = div_take ? alu_out : div_r;
                lo_d     = {lo_q[30:0], div_take};
                state_d  = (cnt_q == 5'd31) ? DONE : DIV;
                cnt_d    = cnt_q + 5'd1;
            end
`endif
            default: begin
                state_d = IDLE;
                if (start) begin
                    err_d = 1'b0;
                    cnt_d = 5'd0;
                    if (!op) begin
                        hi_d    = '0;
                        lo_d    = rt_val;
                        mcand_d = rs_val;
                        state_d = MUL;
                    end else begin
`ifdef MDU_DIV_EN
                        if (rt_val != 32'd0) begin
                            hi_d      = '0;
                            lo_d      = rs_val;
                            divisor_d = rt_val;
                            state_d   = DIV;
                        end else begin
                            hi_d    = rs_val;
                            lo_d    = 32'hFFFF_FFFF;
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
`else
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            err_q     <= 1'b0;
`ifdef MDU_DIV_EN
            divisor_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            err_q     <= err_d;
`ifdef MDU_DIV_EN
            divisor_q <= divisor_d;
`endif
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer with a behavioural ALU alongside.
// Divide expectations follow MDU_DIV_EN, so the same bench covers both builds.
module tb_mdu_sequencer;
    logic        clk, rst_n, start, op, busy, done, err;
    logic [31:0] rs_val, rt_val, hi, lo, alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctl;
    logic [64:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    mdu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .err(err),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
    );

    assign alu_out = (alu_ctl == 4'd2) ? alu_a + alu_b : (alu_ctl == 4'd6) ? alu_a - alu_b : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        if (!o) return {1'b0, 64'(a) * 64'(b)};
`ifdef MDU_DIV_EN
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
`else
        return {1'b1, 64'd0};
`endif
    endfunction

    function automatic int exp_lat(input logic o, input logic [31:0] b);
`ifdef MDU_DIV_EN
        return (o && b == 32'd0) ? 1 : 33;
`else
        return o ? 1 : 33;
`endif
    endfunction

    // call at a negedge; returns just after the accepting edge with operands scrambled
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op = o;
        rs_val = a;
        rt_val = b;
        sb.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_done(output int lat, output int bc, output logic [64:0] res);
        bit got = 0;
        lat = 0;
        bc = 0;
        res = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
            if (done) begin
                res = {err, hi, lo};
                got = 1;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        op = 1'b0;
        rs_val = '0;
        rt_val = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got busy/done/err=%b exp=000", {busy, done, err});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
        end
        checks++;
        if ({alu_ctl, alu_a, alu_b} !== 68'd0) begin
            errors++;
            $display("FAIL reset_alu got ctl=%0d a=%h b=%h exp=0", alu_ctl, alu_a, alu_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] va[5] = '{32'd6, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678, 32'd0};
        logic [31:0] vb[5] = '{32'd7, 32'hFFFF_FFFF, 32'd9, 32'h9ABC_DEF0, 32'd0};
        int lat, bc;
        logic [64:0] res, e;
        va[4] = $urandom;
        vb[4] = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            launch(1'b0, va[i], vb[i]);
            checks++;
            if ({alu_ctl, alu_a, alu_b} !== {4'd2, 32'd0, vb[i][0] ? va[i] : 32'd0}) begin
                errors++;
                $display("FAIL mul_alu_drive[%0d] got ctl=%0d a=%h b=%h exp ctl=2 a=0 b=%h",
                         i, alu_ctl, alu_a, alu_b, vb[i][0] ? va[i] : 32'd0);
            end
            wait_done(lat, bc, res);
            e = sb.size() ? sb.pop_front() : 'x;
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL mul_result[%0d] got err/hi/lo=%h exp=%h", i, res, e);
            end
            checks++;
            if (lat !== 33 || bc !== 32) begin
                errors++;
                $display("FAIL mul_timing[%0d] got lat=%0d busy=%0d exp lat=33 busy=32", i, lat, bc);
            end
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL mul_done_pulse[%0d] got busy/done=%b exp=00", i, {busy, done});
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] va[5] = '{32'd100, 32'hFFFF_FFFF, 32'd7, 32'h8000_0001, 32'd0};
        logic [31:0] vb[5] = '{32'd7, 32'd1, 32'd100, 32'h8000_0000, 32'd0};
        int lat, bc;
        logic [64:0] res, e;
        va[4] = $urandom;
        vb[4] = $urandom_range(32'hFFFF, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            launch(1'b1, va[i], vb[i]);
            wait_done(lat, bc, res);
            e = sb.size() ? sb.pop_front() : 'x;
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL div_result[%0d] got err/hi/lo=%h exp=%h", i, res, e);
            end
            checks++;
            if (lat !== exp_lat(1'b1, vb[i])) begin
                errors++;
                $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(1'b1, vb[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [64:0] res, e;
        @(negedge clk);
        launch(1'b1, 32'd5, 32'd0);
        wait_done(lat, bc, res);
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL divzero_result got err/hi/lo=%h exp=%h", res, e);
        end
        checks++;
        if (lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL divzero_timing got lat=%0d busy=%0d exp lat=1 busy=0", lat, bc);
        end
    endtask

    task automatic test_busy_back_to_back();
        int lat = 0, bc = 0;
        bit got = 0;
        logic [64:0] res, e;
        @(negedge clk);
        launch(1'b0, 32'd6, 32'd7);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
            start = (lat == 10);
            if (lat == 10) begin
                op = 1'b0;
                rs_val = 32'd3;
                rt_val = 32'd3;
            end
            if (done) begin
                res = {err, hi, lo};
                got = 1;
            end
        end
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if (!got || res !== e) begin
            errors++;
            $display("FAIL busy_ignore_result got=%h exp=%h", res, e);
        end
        checks++;
        if (lat !== 33 || bc !== 32) begin
            errors++;
            $display("FAIL busy_ignore_timing got lat=%0d busy=%0d exp lat=33 busy=32", lat, bc);
        end
        if (got) launch(1'b0, 32'd3, 32'd5);
        wait_done(lat, bc, res);
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if (res !== e) begin
            errors++;
            $display("FAIL b2b_result got=%h exp=%h", res, e);
        end
        checks++;
        if (lat !== 33 || bc !== 32) begin
            errors++;
            $display("FAIL b2b_timing got lat=%0d busy=%0d exp lat=33 busy=32", lat, bc);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dones = 0;
        logic [64:0] res, e;
        @(negedge clk);
        launch(1'b0, 32'd6, 32'd7);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL midreset_clear got busy=%b done=%b err=%b hi=%h lo=%h exp all 0",
                     busy, done, err, hi, lo);
        end
        checks++;
        if ({alu_ctl, alu_a, alu_b} !== 68'd0) begin
            errors++;
            $display("FAIL midreset_alu got ctl=%0d a=%h b=%h exp=0", alu_ctl, alu_a, alu_b);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got active cycles=%0d exp=0", dones);
        end
        launch(1'b0, 32'd6, 32'd7);
        wait_done(lat, bc, res);
        e = sb.size() ? sb.pop_front() : 'x;
        checks++;
        if (res !== e || lat !== 33) begin
            errors++;
            $display("FAIL midreset_rerun got=%h lat=%0d exp=%h lat=33", res, lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_busy_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
